hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It sits between the IF/ID register and the opcode decoder. It detects load-use hazards, squashes wrong-path instructions on EX-stage redirects, and drives the decoder with either the real opcode or the BUBBLE opcode. It also runs the ECALL halt-drain sequence that stops fetch and raises `is_halted` once the halting ECALL has retired.

## Interface
- `BUBBLE_OPCODE`, 7'b0000000: opcode substituted toward the decoder; must match the decoder's BUBBLE encoding.
- `DRAIN_CYCLES`, 4: number of cycles spent in DRAIN before halting; legal range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_opcode`  in  7  opcode of instruction currently in ID.
- `id_rs1`, `id_rs2`  in  5 each  source register indices in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `id_rd`  in  5  destination index in ID.
- `id_mem_read`  in  1  decoded mem_read of the ID instruction.
- `id_is_ecall`  in  1  decoded is_ecall of the ID instruction.
- `id_x17_is_10`  in  1  forwarded x17 value equals 10.
- `ex_redirect`  in  1  EX resolved a taken branch, JAL, or JALR target different from the fetched path.
- `pc_write`  out  1  PC update enable.
- `if_id_write`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  IF/ID register clear to bubble.
- `opcode_to_ctrl`  out  7  opcode presented to the decoder.
- `drain_busy`  out  1  high while in DRAIN.
- `is_halted`  out  1  high in HALTED.

## Operation
- **State:**
  - FSM: RUN, DRAIN, HALTED.
  - `drain_cnt`: 4 bits.
  - Shadow of the instruction in EX: `ex_rd_q` (5 bits) and `ex_mem_read_q` (1 bit).
- **Hazard term:** `load_use` = `ex_mem_read_q` && `ex_rd_q`≠0 && ((`id_use_rs1` && `id_rs1`==`ex_rd_q`) || (`id_use_rs2` && `id_rs2`==`ex_rd_q`)).
- **RUN, priority order:**
  1. `ex_redirect`: `if_id_flush`=1, `pc_write`=1, `if_id_write`=1, `opcode_to_ctrl`=BUBBLE. Redirect overrides `load_use` and ECALL.
  2. `load_use`: `pc_write`=0, `if_id_write`=0, `if_id_flush`=0, `opcode_to_ctrl`=BUBBLE.
  3. `id_is_ecall` && `id_x17_is_10`: ECALL passes through unchanged (`opcode_to_ctrl`=`id_opcode`). `pc_write`=0 and `if_id_write`=0 this cycle. Next state DRAIN with `drain_cnt`=`DRAIN_CYCLES`-1.
  4. Otherwise: `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `opcode_to_ctrl`=`id_opcode`.
- An ECALL with `id_x17_is_10`=0 is treated as a normal instruction.
- **DRAIN:**
  - Outputs: `pc_write`=0, `if_id_write`=0, `if_id_flush`=0, `opcode_to_ctrl`=BUBBLE, `drain_busy`=1.
  - `ex_redirect` is ignored; only instructions younger than the ECALL exist, and they are bubbles.
  - `drain_cnt` decrements each cycle. At `drain_cnt`==0 the next state is HALTED.
- **HALTED:** same outputs as DRAIN except `drain_busy`=0 and `is_halted`=1. Left only by `reset`.
- **EX shadow update, every edge:**
  - If a bubble or flush was issued this cycle, or state≠RUN: load `ex_rd_q`=0 and `ex_mem_read_q`=0.
  - Otherwise: load `id_rd` and `id_mem_read`.
- **Reset values:**
  - Internal: state=RUN, `drain_cnt`=0, `ex_rd_q`=0, `ex_mem_read_q`=0.
  - Outputs: `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `opcode_to_ctrl`=`id_opcode`, `drain_busy`=0, `is_halted`=0.

## Timing
- Outputs are combinational from the current state, the EX shadow, and the ID inputs. There are no input-to-state paths other than the edge updates above.
- **Load-use:** exactly one stall cycle per hazard. On the following cycle the shadow is clear, so the same ID instruction proceeds.
- **Redirect:** flush is asserted in the same cycle as `ex_redirect`. The next cycle is RUN with a clear shadow.
- **ECALL halt:** ECALL detected in ID in cycle t.
  - DRAIN for cycles t+1 .. t+`DRAIN_CYCLES`.
  - `is_halted`=1 from cycle t+`DRAIN_CYCLES`+1 onward.
- **Reset:** asynchronous assertion at any point, including mid-DRAIN or in HALTED, immediately forces the RUN outputs. The first post-reset edge behaves as RUN.

## Test plan
- **Load-use stall:**
  - Stimulus: cycle k, ID holds `lw x5` (`id_rd`=5, `id_mem_read`=1). Cycle k+1, ID holds `add x6,x5,x1` (`id_use_rs1`=1, `id_rs1`=5).
  - Required: in cycle k+1, `pc_write`=0, `if_id_write`=0, `opcode_to_ctrl`=0000000. In cycle k+2, normal pass-through with `opcode_to_ctrl`=0110011.
- **x0 exemption:**
  - Stimulus: `lw x0` followed by an instruction with `id_rs1`=0.
  - Required: no stall; `pc_write` stays 1.
- **Redirect over hazard:**
  - Stimulus: load-use condition and `ex_redirect`=1 in the same cycle.
  - Required: `if_id_flush`=1, `pc_write`=1, BUBBLE. The next cycle has no stall because the shadow is cleared.
- **Halt sequence:**
  - Stimulus: `id_is_ecall`=1, `id_x17_is_10`=1 at cycle t, with `DRAIN_CYCLES`=4.
  - Required: `drain_busy`=1 for t+1..t+4. `is_halted`=1 at t+5 and later. `pc_write`=0 throughout. Toggling `ex_redirect` during DRAIN has no effect.
- **Non-halting ECALL:**
  - Stimulus: `id_is_ecall`=1, `id_x17_is_10`=0.
  - Required: outputs identical to a normal instruction; state stays RUN.
- **Reset mid-drain:**
  - Stimulus: assert `reset` at t+2 of a halt sequence, asynchronously between edges.
  - Required: `drain_busy`=0, `pc_write`=1 immediately. After release, a new load-use case stalls correctly.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard and sequencing controller between IF/ID and the opcode decoder:
// load-use stalls, redirect squashes, and the ECALL drain-then-halt sequence.
module hazard_control_unit #(
  parameter logic [6:0]  BUBBLE_OPCODE = 7'b0000000,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_id_opcode,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_id_rd,
  input  logic       i_id_mem_read,
  input  logic       i_id_is_ecall,
  input  logic       i_id_x17_is_10,
  input  logic       i_ex_redirect,
  output logic       o_pc_write,
  output logic       o_if_id_write,
  output logic       o_if_id_flush,
  output logic [6:0] o_opcode_to_ctrl,
  output logic       o_drain_busy,
  output logic       o_is_halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_drain_cnt;
  logic [3:0] w_drain_cnt_next;
  logic [4:0] r_ex_rd_q;
  logic       r_ex_mem_read_q;
  logic       w_load_use;
  logic       w_halt_req;
  logic       w_squash;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign w_load_use = r_ex_mem_read_q && (r_ex_rd_q != 5'd0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == r_ex_rd_q)) ||
                       (i_id_use_rs2 && (i_id_rs2 == r_ex_rd_q)));
  assign w_halt_req = i_id_is_ecall && i_id_x17_is_10;

  always_comb begin
    o_pc_write       = 1'b1;
    o_if_id_write    = 1'b1;
    o_if_id_flush    = 1'b0;
    o_opcode_to_ctrl = i_id_opcode;
    o_drain_busy     = 1'b0;
    o_is_halted      = 1'b0;
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    w_squash         = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_ex_redirect) begin
          o_if_id_flush    = 1'b1;
          o_opcode_to_ctrl = BUBBLE_OPCODE;
          w_squash         = 1'b1;
        end else if (w_load_use) begin
          o_pc_write       = 1'b0;
          o_if_id_write    = 1'b0;
          o_opcode_to_ctrl = BUBBLE_OPCODE;
          w_squash         = 1'b1;
        end else if (w_halt_req) begin
          // The ECALL itself retires; only fetch is frozen behind it.
          o_pc_write       = 1'b0;
          o_if_id_write    = 1'b0;
          w_state_next     = ST_DRAIN;
          w_drain_cnt_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        o_pc_write       = 1'b0;
        o_if_id_write    = 1'b0;
        o_opcode_to_ctrl = BUBBLE_OPCODE;
        o_drain_busy     = 1'b1;
        w_squash         = 1'b1;
        if (r_drain_cnt == 4'd0) begin
          w_state_next = ST_HALTED;
        end else begin
          w_drain_cnt_next = r_drain_cnt - 4'd1;
        end
      end
      ST_HALTED: begin
        o_pc_write       = 1'b0;
        o_if_id_write    = 1'b0;
        o_opcode_to_ctrl = BUBBLE_OPCODE;
        o_is_halted      = 1'b1;
        w_squash         = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  // Shadow of what enters EX next; bubbles carry no destination.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex_rd_q       <= 5'd0;
      r_ex_mem_read_q <= 1'b0;
    end else if (w_squash) begin
      r_ex_rd_q       <= 5'd0;
      r_ex_mem_read_q <= 1'b0;
    end else begin
      r_ex_rd_q       <= i_id_rd;
      r_ex_mem_read_q <= i_id_mem_read;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios plus random
// traffic, checked against a cycle-count based reference model.
module tb_hazard_control_unit;

  localparam int         DRAIN  = 4;
  localparam logic [6:0] BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       flush;
    logic [6:0] op;
    logic       busy;
    logic       halted;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] idOpcode = 7'd0;
  logic [4:0] idRs1 = 5'd0, idRs2 = 5'd0, idRd = 5'd0;
  logic       idUseRs1 = 1'b0, idUseRs2 = 1'b0, idMemRead = 1'b0;
  logic       idIsEcall = 1'b0, idX17Is10 = 1'b0, exRedirect = 1'b0;
  logic       pcWrite, ifIdWrite, ifIdFlush, drainBusy, isHalted;
  logic [6:0] opcodeToCtrl;

  exp_t  expQ[$];
  string tagQ[$];
  int    total = 0;
  int    bad = 0;
  string curTag = "reset";

  // Model: mode derives from the cycle number relative to the halting ECALL;
  // the EX slot remembers which real instruction was issued last cycle.
  int         mCycle = 0, mHaltAt = -1;
  logic       mExValid = 1'b0, mExMem = 1'b0;
  logic [4:0] mExRd = 5'd0;
  int         pCycle = 0, pHaltAt = -1;
  logic       pExValid = 1'b0, pExMem = 1'b0;
  logic [4:0] pExRd = 5'd0;

  always #5 clk = ~clk;

  hazard_control_unit #(.BUBBLE_OPCODE(BUBBLE), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_reset(reset), .i_id_opcode(idOpcode),
    .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_use_rs1(idUseRs1), .i_id_use_rs2(idUseRs2),
    .i_id_rd(idRd), .i_id_mem_read(idMemRead),
    .i_id_is_ecall(idIsEcall), .i_id_x17_is_10(idX17Is10),
    .i_ex_redirect(exRedirect),
    .o_pc_write(pcWrite), .o_if_id_write(ifIdWrite), .o_if_id_flush(ifIdFlush),
    .o_opcode_to_ctrl(opcodeToCtrl), .o_drain_busy(drainBusy), .o_is_halted(isHalted)
  );

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr, input logic ec,
                               input logic x17, input logic redir, input logic rst);
    exp_t e;
    bit   lu;
    bit   issued;
    int   mode;
    @(posedge clk);
    #1;
    mCycle = pCycle; mHaltAt = pHaltAt;
    mExValid = pExValid; mExRd = pExRd; mExMem = pExMem;
    idOpcode = op; idRs1 = rs1; idRs2 = rs2; idUseRs1 = u1; idUseRs2 = u2;
    idRd = rd; idMemRead = mr; idIsEcall = ec; idX17Is10 = x17;
    exRedirect = redir; reset = rst;
    if (rst) begin
      mCycle = 0; mHaltAt = -1; mExValid = 1'b0;
    end
    if (mHaltAt < 0 || mCycle <= mHaltAt) mode = 0;
    else if (mCycle <= mHaltAt + DRAIN) mode = 1;
    else mode = 2;
    lu = mExValid && mExMem && (mExRd != 5'd0) &&
         ((u1 && rs1 == mExRd) || (u2 && rs2 == mExRd));
    e = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, op: op, busy: 1'b0, halted: 1'b0};
    issued = 1'b0;
    if (mode == 0) begin
      if (redir) begin
        e.flush = 1'b1; e.op = BUBBLE;
      end else if (lu) begin
        e.pc = 1'b0; e.ifid = 1'b0; e.op = BUBBLE;
      end else begin
        issued = 1'b1;
        if (ec && x17) begin
          e.pc = 1'b0; e.ifid = 1'b0;
        end
      end
    end else begin
      e.pc = 1'b0; e.ifid = 1'b0; e.op = BUBBLE;
      e.busy = (mode == 1); e.halted = (mode == 2);
    end
    expQ.push_back(e);
    tagQ.push_back(curTag);
    if (rst) begin
      pCycle = 0; pHaltAt = -1; pExValid = 1'b0; pExRd = 5'd0; pExMem = 1'b0;
    end else begin
      pCycle   = mCycle + 1;
      pHaltAt  = (issued && ec && x17) ? mCycle : mHaltAt;
      pExValid = issued; pExRd = rd; pExMem = mr;
    end
  endtask

  task automatic normalOp(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rd,
                          input logic mr, input logic redir);
    applyStimulus(op, rs1, 5'd0, 1'b1, 1'b0, rd, mr, 1'b0, 1'b0, redir, 1'b0);
  endtask

  task automatic randomCycle();
    logic [6:0] ops [6];
    logic [6:0] op;
    logic       ec;
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_I;
    ops[3] = 7'b1100011; ops[4] = 7'b1101111; ops[5] = 7'b0100011;
    ec = ($urandom_range(0, 24) == 0);
    op = ec ? OP_SYS : ops[$urandom_range(0, 5)];
    applyStimulus(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ec,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0);
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    exp_t a;
    a = '{pc: pcWrite, ifid: ifIdWrite, flush: ifIdFlush, op: opcodeToCtrl,
          busy: drainBusy, halted: isHalted};
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got pc=%b ifid=%b flush=%b op=%b busy=%b halt=%b expected pc=%b ifid=%b flush=%b op=%b busy=%b halt=%b",
               tag, $time, a.pc, a.ifid, a.flush, a.op, a.busy, a.halted,
               e.pc, e.ifid, e.flush, e.op, e.busy, e.halted);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    curTag = "reset";
    applyStimulus(OP_R, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    curTag = "loaduse";
    normalOp(OP_LW, 5'd2, 5'd5, 1'b1, 1'b0);
    normalOp(OP_R, 5'd5, 5'd6, 1'b0, 1'b0);
    normalOp(OP_R, 5'd5, 5'd6, 1'b0, 1'b0);
    applyStimulus(OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_R, 5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_R, 5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    curTag = "x0exempt";
    normalOp(OP_LW, 5'd2, 5'd0, 1'b1, 1'b0);
    normalOp(OP_R, 5'd0, 5'd6, 1'b0, 1'b0);

    curTag = "redirect";
    normalOp(OP_LW, 5'd2, 5'd9, 1'b1, 1'b0);
    normalOp(OP_R, 5'd9, 5'd6, 1'b0, 1'b1);
    normalOp(OP_R, 5'd9, 5'd6, 1'b0, 1'b0);

    curTag = "ecall_nohalt";
    applyStimulus(OP_SYS, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    normalOp(OP_I, 5'd1, 5'd2, 1'b0, 1'b0);

    curTag = "halt";
    applyStimulus(OP_SYS, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DRAIN + 3; i++) normalOp(OP_R, 5'd1, 5'd2, 1'b0, 1'(i % 2));

    curTag = "reset_mid_drain";
    applyStimulus(OP_R, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_SYS, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    normalOp(OP_R, 5'd1, 5'd2, 1'b0, 1'b0);
    applyStimulus(OP_R, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_R, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    normalOp(OP_LW, 5'd2, 5'd5, 1'b1, 1'b0);
    normalOp(OP_R, 5'd5, 5'd6, 1'b0, 1'b0);
    normalOp(OP_R, 5'd5, 5'd6, 1'b0, 1'b0);

    curTag = "random";
    for (int ep = 0; ep < 20; ep++) begin
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 30; c++) randomCycle();
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_queue left=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
